// File: rtl/bidir_link_pkg.sv
// Shared types and sizing for the bidirectional link controller.
package bidir_link_pkg;

  typedef enum logic [1:0] {
    RX_IDLE = 2'd0,
    TURN_TX = 2'd1,
    TX      = 2'd2,
    TURN_RX = 2'd3
  } link_state_e;

  localparam int TURN_CYCLES_DEF = 2;
  localparam int MAX_BURST_DEF   = 16;

  // Turnaround counter covers 1..15, burst counter covers 0..254.
  localparam int TURN_CNT_W  = 4;
  localparam int BURST_CNT_W = 8;

endpackage

// File: rtl/bidir_link_ctrl_if.sv
// Local-side tx/rx handshake bundle of the link controller.
interface bidir_link_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             tx_valid;
  logic [WIDTH-1:0] tx_data;
  logic             tx_ready;
  logic             rx_valid;
  logic [WIDTH-1:0] rx_data;
  logic             rx_ready;

  // Local user of the link.
  modport master (
    output tx_valid, tx_data, rx_ready,
    input  tx_ready, rx_valid, rx_data
  );

  // The link controller.
  modport slave (
    input  tx_valid, tx_data, rx_ready,
    output tx_ready, rx_valid, rx_data
  );
endinterface

// File: rtl/bidir_rx_hold.sv
// Single-word receive holding register with valid/ready handshake and
// sticky overrun detection.
module bidir_rx_hold #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cap_en,
  input  logic             bus_vld,
  input  logic [WIDTH-1:0] bus_data,
  input  logic             rx_ready,
  input  logic             err_clr,
  output logic             rx_valid,
  output logic [WIDTH-1:0] rx_data,
  output logic             overrun_err
);

  logic cap_req;
  logic accept;
  logic overrun_evt;

  assign cap_req     = cap_en && bus_vld;
  assign accept      = cap_req && (!rx_valid || rx_ready);
  assign overrun_evt = cap_req && rx_valid && !rx_ready;

  // Load a new word when the slot frees this cycle; otherwise drain on rx_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_valid <= 1'b0;
      rx_data  <= '0;
    end else if (accept) begin
      rx_valid <= 1'b1;
      rx_data  <= bus_data;
    end else if (rx_ready) begin
      rx_valid <= 1'b0;
    end
  end

  // Sticky overrun flag; a new event beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_err <= 1'b0;
    end else if (overrun_evt) begin
      overrun_err <= 1'b1;
    end else if (err_clr) begin
      overrun_err <= 1'b0;
    end
  end

endmodule

// File: rtl/bidir_link_ctrl.sv
// Half-duplex link controller: arbitrates a shared tristate data bus between
// this end and a peer, inserting dead cycles at every direction change.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   RX_IDLE | peer may drive; words qualified by bus_vld are captured
//   TURN_TX | bus claimed (bus_dir=1), waiting out the dead cycles
//   TX      | driving tx_data while tx_valid, up to MAX_BURST words
//   TURN_RX | bus still claimed but released, dead cycles before RX_IDLE
//
// The TX cycle in which tx_valid drops already leaves the bus undriven, so it
// counts as the first dead cycle of the return turnaround; a burst ended by
// MAX_BURST gets the full TURN_CYCLES in TURN_RX.
module bidir_link_ctrl
  import bidir_link_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int TURN_CYCLES = TURN_CYCLES_DEF,
  parameter int MAX_BURST   = MAX_BURST_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  bidir_link_ctrl_if.slave lnk,
  inout  wire [WIDTH-1:0]  bus_dq,
  output logic             bus_dir,
  output logic             bus_stb,
  input  logic             bus_vld,
  input  logic             err_clr,
  output logic             overrun_err,
  output logic             collision_err
);

  localparam logic [TURN_CNT_W-1:0]  TURN_LOAD       = TURN_CNT_W'(TURN_CYCLES);
  localparam logic [TURN_CNT_W-1:0]  TURN_LOAD_SHORT = TURN_CNT_W'(TURN_CYCLES - 1);
  localparam logic [BURST_CNT_W-1:0] BURST_LAST      = BURST_CNT_W'(MAX_BURST - 1);

  link_state_e             state, state_nx;
  logic [TURN_CNT_W-1:0]   turn_cnt, turn_nx;
  logic [BURST_CNT_W-1:0]  burst_cnt, burst_nx;
  logic                    drive_bus;
  logic                    rx_window;
  logic                    collision_evt;

  assign drive_bus     = (state == TX) && lnk.tx_valid;
  assign bus_dq        = drive_bus ? lnk.tx_data : {WIDTH{1'bz}};
  assign bus_stb       = drive_bus;
  assign bus_dir       = (state != RX_IDLE);
  assign lnk.tx_ready  = (state == TX);
  assign rx_window     = (state == RX_IDLE);
  assign collision_evt = bus_vld && !rx_window;

  // State and counter registers; reset drops the bus with no dead cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RX_IDLE;
      turn_cnt  <= '0;
      burst_cnt <= '0;
    end else begin
      state     <= state_nx;
      turn_cnt  <= turn_nx;
      burst_cnt <= burst_nx;
    end
  end

  // Next-state logic with down-counting turnaround and burst limit.
  always_comb begin
    state_nx = state;
    turn_nx  = turn_cnt;
    burst_nx = burst_cnt;
    unique case (state)
      RX_IDLE: begin
        if (lnk.tx_valid) begin
          state_nx = TURN_TX;
          turn_nx  = TURN_LOAD;
        end
      end
      TURN_TX: begin
        if (turn_cnt <= 4'd1) begin
          state_nx = TX;
          turn_nx  = '0;
        end else begin
          turn_nx = turn_cnt - 1'b1;
        end
      end
      TX: begin
        if (!lnk.tx_valid) begin
          burst_nx = '0;
          if (TURN_CYCLES == 1) begin
            state_nx = RX_IDLE;
            turn_nx  = '0;
          end else begin
            state_nx = TURN_RX;
            turn_nx  = TURN_LOAD_SHORT;
          end
        end else if (burst_cnt == BURST_LAST) begin
          state_nx = TURN_RX;
          turn_nx  = TURN_LOAD;
          burst_nx = '0;
        end else begin
          burst_nx = burst_cnt + 1'b1;
        end
      end
      TURN_RX: begin
        burst_nx = '0;
        if (turn_cnt <= 4'd1) begin
          state_nx = RX_IDLE;
          turn_nx  = '0;
        end else begin
          turn_nx = turn_cnt - 1'b1;
        end
      end
      default: begin
        state_nx = RX_IDLE;
        turn_nx  = '0;
        burst_nx = '0;
      end
    endcase
  end

  // Sticky collision flag: peer drove while this end owned the bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      collision_err <= 1'b0;
    end else if (collision_evt) begin
      collision_err <= 1'b1;
    end else if (err_clr) begin
      collision_err <= 1'b0;
    end
  end

  bidir_rx_hold #(.WIDTH(WIDTH)) u_rx_hold (
    .clk        (clk),
    .rst_n      (rst_n),
    .cap_en     (rx_window),
    .bus_vld    (bus_vld),
    .bus_data   (bus_dq),
    .rx_ready   (lnk.rx_ready),
    .err_clr    (err_clr),
    .rx_valid   (lnk.rx_valid),
    .rx_data    (lnk.rx_data),
    .overrun_err(overrun_err)
  );

endmodule

// File: tb/tb_bidir_link_ctrl.sv
// Scoreboard bench for bidir_link_ctrl: directed tx bursts, peer words,
// error flags and mid-burst reset.
module tb_bidir_link_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         bus_vld = 1'b0;
  logic         err_clr = 1'b0;
  logic         peer_oe = 1'b0;
  logic [W-1:0] peer_data = '0;
  wire  [W-1:0] bus_dq;
  logic         bus_dir, bus_stb, overrun_err, collision_err;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int t0;

  logic [W-1:0] exp_bus[$];
  logic [W-1:0] exp_rx[$];
  logic [W-1:0] tx_q[$];
  int           word_cyc[$];
  logic         dir_log[0:4095];
  logic         hz_log[0:4095];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign bus_dq = peer_oe ? peer_data : {W{1'bz}};

  bidir_link_ctrl_if #(.WIDTH(W)) lnk ();

  bidir_link_ctrl #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .lnk          (lnk),
    .bus_dq       (bus_dq),
    .bus_dir      (bus_dir),
    .bus_stb      (bus_stb),
    .bus_vld      (bus_vld),
    .err_clr      (err_clr),
    .overrun_err  (overrun_err),
    .collision_err(collision_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic released();
    return (bus_dq === {W{1'bz}}) || (bus_dq === {W{1'b0}});
  endfunction

  // Monitor: pops the scoreboard whenever the DUT presents a bus word or an rx handshake.
  always @(negedge clk) begin
    if (cyc < 4096) begin
      dir_log[cyc] <= bus_dir;
      hz_log[cyc]  <= !peer_oe && released();
    end
    if (peer_oe) check("no_contention", {31'd0, bus_stb}, 32'd0);
    if (bus_stb) begin
      word_cyc.push_back(cyc);
      check("bus_dir_while_tx", {31'd0, bus_dir}, 32'd1);
      if (exp_bus.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL bus_word: got unexpected %0h, expected none", bus_dq);
      end else begin
        check("bus_word", {24'd0, bus_dq}, {24'd0, exp_bus.pop_front()});
      end
    end
    if (lnk.rx_valid && lnk.rx_ready) begin
      if (exp_rx.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL rx_word: got unexpected %0h, expected none", lnk.rx_data);
      end else begin
        check("rx_word", {24'd0, lnk.rx_data}, {24'd0, exp_rx.pop_front()});
      end
    end
  end

  task automatic queue_word(input logic [W-1:0] w);
    tx_q.push_back(w);
    exp_bus.push_back(w);
  endtask

  // Drives tx_q through the tx handshake; call just after a rising edge.
  task automatic send_all();
    int   budget = 100;
    logic took;
    logic [W-1:0] dummy;
    lnk.tx_valid = 1'b1;
    lnk.tx_data  = tx_q[0];
    while (tx_q.size() > 0 && budget > 0) begin
      @(negedge clk);
      took = lnk.tx_ready;
      @(posedge clk); #1;
      budget--;
      if (took) begin
        dummy = tx_q.pop_front();
        if (tx_q.size() > 0) lnk.tx_data = tx_q[0];
      end
    end
    lnk.tx_valid = 1'b0;
    if (budget == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL tx_send_timeout: %0d words left, expected 0", tx_q.size());
      tx_q.delete();
    end
  endtask

  // One peer word on the bus for one cycle; call just after a rising edge.
  task automatic peer_pulse(input logic [W-1:0] w);
    peer_oe   = 1'b1;
    peer_data = w;
    bus_vld   = 1'b1;
    @(posedge clk); #1;
    peer_oe = 1'b0;
    bus_vld = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected finish");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    lnk.tx_valid = 1'b0;
    lnk.tx_data  = '0;
    lnk.rx_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset values
    @(negedge clk);
    check("rst_bus_dir", {31'd0, bus_dir}, 32'd0);
    check("rst_bus_stb", {31'd0, bus_stb}, 32'd0);
    check("rst_tx_ready", {31'd0, lnk.tx_ready}, 32'd0);
    check("rst_rx_valid", {31'd0, lnk.rx_valid}, 32'd0);
    check("rst_rx_data", {24'd0, lnk.rx_data}, 32'd0);
    check("rst_errs", {30'd0, overrun_err, collision_err}, 32'd0);
    check("rst_released", {31'd0, released()}, 32'd1);

    // Three-word burst timing
    @(posedge clk); #1;
    t0 = cyc;
    word_cyc.delete();
    queue_word(8'hA1); queue_word(8'hA2); queue_word(8'hA3);
    send_all();
    repeat (6) @(posedge clk); #1;
    check("b3_count", word_cyc.size(), 32'd3);
    check("b3_w1_cyc", word_cyc[0] - t0, 32'd3);
    check("b3_w2_cyc", word_cyc[1] - t0, 32'd4);
    check("b3_w3_cyc", word_cyc[2] - t0, 32'd5);
    check("b3_dir_c0", {31'd0, dir_log[t0]}, 32'd0);
    check("b3_dir_c1", {31'd0, dir_log[t0+1]}, 32'd1);
    check("b3_hz_c6", {31'd0, hz_log[t0+6]}, 32'd1);
    check("b3_hz_c7", {31'd0, hz_log[t0+7]}, 32'd1);
    check("b3_dir_c7", {31'd0, dir_log[t0+7]}, 32'd1);
    check("b3_dir_c8", {31'd0, dir_log[t0+8]}, 32'd0);

    // Twenty words against MAX_BURST=16
    t0 = cyc;
    word_cyc.delete();
    for (int i = 0; i < 20; i++) queue_word(8'h10 + 8'(i));
    send_all();
    repeat (6) @(posedge clk); #1;
    check("b20_count", word_cyc.size(), 32'd20);
    check("b20_w16_cyc", word_cyc[15] - t0, 32'd18);
    check("b20_gap", word_cyc[16] - word_cyc[15], 32'd6);
    check("b20_w20_cyc", word_cyc[19] - t0, 32'd27);
    check("b20_dir_turnrx", {31'd0, dir_log[t0+20]}, 32'd1);
    check("b20_dir_idle", {31'd0, dir_log[t0+21]}, 32'd0);
    check("b20_dir_turntx", {31'd0, dir_log[t0+22]}, 32'd1);

    // Overrun: held word survives, flag sets, clear works, event beats clear
    lnk.rx_ready = 1'b0;
    exp_rx.push_back(8'h5C);
    peer_pulse(8'h5C);
    peer_pulse(8'h77);
    @(negedge clk);
    check("ovr_flag", {31'd0, overrun_err}, 32'd1);
    check("ovr_rx_valid", {31'd0, lnk.rx_valid}, 32'd1);
    check("ovr_rx_data", {24'd0, lnk.rx_data}, 32'h5C);
    @(posedge clk); #1 err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
    check("ovr_cleared", {31'd0, overrun_err}, 32'd0);
    err_clr = 1'b1;
    peer_pulse(8'h88);
    err_clr = 1'b0;
    check("ovr_beats_clr", {31'd0, overrun_err}, 32'd1);
    check("ovr_rx_data2", {24'd0, lnk.rx_data}, 32'h5C);
    err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
    check("ovr_cleared2", {31'd0, overrun_err}, 32'd0);

    // Drain, then back-to-back words while rx_ready stays high
    lnk.rx_ready = 1'b1;
    exp_rx.push_back(8'h61);
    exp_rx.push_back(8'h62);
    peer_pulse(8'h61);
    peer_pulse(8'h62);
    repeat (2) @(posedge clk); #1;
    check("b2b_no_overrun", {31'd0, overrun_err}, 32'd0);
    check("b2b_drained", {31'd0, lnk.rx_valid}, 32'd0);

    // Collision during TURN_TX
    queue_word(8'hC5);
    fork
      send_all();
      begin
        @(posedge clk); #1;
        peer_pulse(8'hEE);
      end
    join
    check("col_flag", {31'd0, collision_err}, 32'd1);
    check("col_rx_valid", {31'd0, lnk.rx_valid}, 32'd0);
    check("col_rx_data", {24'd0, lnk.rx_data}, 32'h62);
    check("col_no_ovr", {31'd0, overrun_err}, 32'd0);
    repeat (4) @(posedge clk); #1;

    // Reset in the middle of TX word 2
    lnk.rx_ready = 1'b0;
    peer_pulse(8'h9D);
    exp_bus.push_back(8'hB1);
    exp_bus.push_back(8'hB2);
    lnk.tx_valid = 1'b1;
    lnk.tx_data  = 8'hB1;
    repeat (4) @(posedge clk);
    #1 lnk.tx_data = 8'hB2;
    @(negedge clk);
    #2;
    check("pre_rst_held", {24'd0, lnk.rx_data}, 32'h9D);
    rst_n = 1'b0;
    lnk.tx_valid = 1'b0;
    #1;
    check("mid_rst_dir", {31'd0, bus_dir}, 32'd0);
    check("mid_rst_released", {31'd0, released()}, 32'd1);
    check("mid_rst_stb", {31'd0, bus_stb}, 32'd0);
    check("mid_rst_tx_ready", {31'd0, lnk.tx_ready}, 32'd0);
    check("mid_rst_rx", {23'd0, lnk.rx_valid, lnk.rx_data}, 32'd0);
    check("mid_rst_errs", {30'd0, overrun_err, collision_err}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_dir", {31'd0, bus_dir}, 32'd0);
    check("post_rst_tx_ready", {31'd0, lnk.tx_ready}, 32'd0);

    // Peer word and tx_valid in the same RX_IDLE cycle
    lnk.rx_ready = 1'b1;
    @(posedge clk); #1;
    t0 = cyc;
    exp_rx.push_back(8'h3E);
    queue_word(8'hC1);
    fork
      send_all();
      peer_pulse(8'h3E);
    join
    check("same_cyc_dir", {31'd0, dir_log[t0+1]}, 32'd1);
    check("same_cyc_no_col", {31'd0, collision_err}, 32'd0);
    repeat (6) @(posedge clk); #1;

    check("bus_sb_empty", exp_bus.size(), 32'd0);
    check("rx_sb_empty", exp_rx.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
